// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite slave exposing NUM_REGS control/status words; word 0 is a constant ID.
// Write address and data are buffered independently and commit together one cycle later.
module axi4lite_slave_regfile #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 8,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA41C0001
) (
  input  logic                           A_CLK,
  input  logic                           A_RSTn,
  input  logic                           AW_VALID,
  output logic                           AW_READY,
  input  logic [ADDR_WIDTH-1:0]          AW_ADDR,
  input  logic                           W_VALID,
  output logic                           W_READY,
  input  logic [DATA_WIDTH-1:0]          W_DATA,
  output logic                           B_VALID,
  input  logic                           B_READY,
  output logic [1:0]                     B_RESP,
  input  logic                           AR_VALID,
  output logic                           AR_READY,
  input  logic [ADDR_WIDTH-1:0]          AR_ADDR,
  output logic                           R_VALID,
  input  logic                           R_READY,
  output logic [DATA_WIDTH-1:0]          R_DATA,
  output logic [1:0]                     R_RESP,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REGS
);

  localparam int         IDX_W  = $clog2(NUM_REGS);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic                  rst_hold_r;
  logic                  aw_full_r;
  logic                  w_full_r;
  logic [IDX_W-1:0]      aw_idx_r;
  logic                  aw_in_range_r;
  logic [DATA_WIDTH-1:0] w_data_r;
  logic                  b_valid_r;
  logic [1:0]            b_resp_r;
  logic                  r_valid_r;
  logic [DATA_WIDTH-1:0] r_data_r;
  logic [1:0]            r_resp_r;

  logic                  aw_ready_s;
  logic                  w_ready_s;
  logic                  ar_ready_s;
  logic                  aw_hs_s;
  logic                  w_hs_s;
  logic                  ar_hs_s;
  logic                  commit_s;
  logic                  wr_ok_s;
  logic [IDX_W-1:0]      aw_idx_s;
  logic                  aw_in_range_s;
  logic [IDX_W-1:0]      ar_idx_s;
  logic                  ar_in_range_s;
  logic [DATA_WIDTH-1:0] reg_view_s [NUM_REGS];
  logic                  unused_s;

  // Byte-lane bits are ignored; anything above the register window is out of range.
  assign aw_idx_s      = AW_ADDR[IDX_W+1:2];
  assign ar_idx_s      = AR_ADDR[IDX_W+1:2];
  assign aw_in_range_s = (AW_ADDR[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign ar_in_range_s = (AR_ADDR[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign unused_s      = ^{AW_ADDR[1:0], AR_ADDR[1:0]};

  // Handshake readiness and commit qualification.
  always_comb begin
    aw_ready_s = 1'b0;
    w_ready_s  = 1'b0;
    ar_ready_s = 1'b0;
    if (!rst_hold_r) begin
      aw_ready_s = !aw_full_r && !b_valid_r;
      w_ready_s  = !w_full_r && !b_valid_r;
      ar_ready_s = !r_valid_r;
    end else begin
      aw_ready_s = 1'b0;
      w_ready_s  = 1'b0;
      ar_ready_s = 1'b0;
    end
  end

  assign aw_hs_s  = AW_VALID && aw_ready_s;
  assign w_hs_s   = W_VALID && w_ready_s;
  assign ar_hs_s  = AR_VALID && ar_ready_s;
  assign commit_s = aw_full_r && w_full_r;
  assign wr_ok_s  = aw_in_range_r && (aw_idx_r != {IDX_W{1'b0}});

  // Hold the slave quiet for the first edge after reset release.
  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) rst_hold_r <= 1'b1;
    else         rst_hold_r <= 1'b0;
  end

  // Write channel buffering, commit and response.
  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      aw_full_r     <= 1'b0;
      w_full_r      <= 1'b0;
      aw_idx_r      <= {IDX_W{1'b0}};
      aw_in_range_r <= 1'b0;
      w_data_r      <= {DATA_WIDTH{1'b0}};
      b_valid_r     <= 1'b0;
      b_resp_r      <= OKAY;
    end else begin
      if (aw_hs_s) begin
        aw_full_r     <= 1'b1;
        aw_idx_r      <= aw_idx_s;
        aw_in_range_r <= aw_in_range_s;
      end
      if (w_hs_s) begin
        w_full_r <= 1'b1;
        w_data_r <= W_DATA;
      end
      if (commit_s) begin
        aw_full_r <= 1'b0;
        w_full_r  <= 1'b0;
        b_valid_r <= 1'b1;
        b_resp_r  <= wr_ok_s ? OKAY : SLVERR;
      end else if (b_valid_r && B_READY) begin
        b_valid_r <= 1'b0;
      end
    end
  end

  // Read channel: data is captured at the handshake, so a same-edge commit is not seen.
  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      r_valid_r <= 1'b0;
      r_data_r  <= {DATA_WIDTH{1'b0}};
      r_resp_r  <= OKAY;
    end else begin
      if (ar_hs_s) begin
        r_valid_r <= 1'b1;
        if (ar_in_range_s) begin
          r_data_r <= reg_view_s[ar_idx_s];
          r_resp_r <= OKAY;
        end else begin
          r_data_r <= {DATA_WIDTH{1'b0}};
          r_resp_r <= SLVERR;
        end
      end else if (r_valid_r && R_READY) begin
        r_valid_r <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (g == 0) begin : g_id
      assign reg_view_s[g] = ID_VALUE;
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] reg_r;
      // Register storage, updated on the commit edge.
      always_ff @(posedge A_CLK or negedge A_RSTn) begin
        if (!A_RSTn) begin
          reg_r <= {DATA_WIDTH{1'b0}};
        end else if (commit_s && wr_ok_s && (aw_idx_r == IDX_W'(g))) begin
          reg_r <= w_data_r;
        end
      end
      assign reg_view_s[g] = reg_r;
    end
    assign REGS[g*DATA_WIDTH +: DATA_WIDTH] = reg_view_s[g];
  end

  assign AW_READY = aw_ready_s;
  assign W_READY  = w_ready_s;
  assign AR_READY = ar_ready_s;
  assign B_VALID  = b_valid_r;
  assign B_RESP   = b_resp_r;
  assign R_VALID  = r_valid_r;
  assign R_DATA   = r_data_r;
  assign R_RESP   = r_resp_r;

endmodule
